// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative RV64M multiply/divide unit and its decoder:
// MULctr codes, opcode classification helpers and the unit's state encoding.
package mdu_pkg;

   localparam int MDU_XLEN = 64;

   localparam logic [3:0] MDU_NONE   = 4'b0000;
   localparam logic [3:0] MDU_MUL    = 4'b1001;
   localparam logic [3:0] MDU_MULH   = 4'b0001;
   localparam logic [3:0] MDU_MULHSU = 4'b0010;
   localparam logic [3:0] MDU_MULHU  = 4'b0011;
   localparam logic [3:0] MDU_DIV    = 4'b0100;
   localparam logic [3:0] MDU_DIVU   = 4'b0101;
   localparam logic [3:0] MDU_REM    = 4'b0110;
   localparam logic [3:0] MDU_REMU   = 4'b0111;
   localparam logic [3:0] MDU_MULW   = 4'b1000;
   localparam logic [3:0] MDU_DIVW   = 4'b1100;
   localparam logic [3:0] MDU_DIVUW  = 4'b1101;
   localparam logic [3:0] MDU_REMW   = 4'b1110;
   localparam logic [3:0] MDU_REMUW  = 4'b1111;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } mdu_state_e;

   function automatic logic is_w(input logic [3:0] op);
      return op inside {MDU_MULW, MDU_DIVW, MDU_DIVUW, MDU_REMW, MDU_REMUW};
   endfunction

   function automatic logic is_div(input logic [3:0] op);
      return op inside {MDU_DIV, MDU_DIVU, MDU_REM, MDU_REMU,
                        MDU_DIVW, MDU_DIVUW, MDU_REMW, MDU_REMUW};
   endfunction

   function automatic logic is_rem(input logic [3:0] op);
      return op inside {MDU_REM, MDU_REMU, MDU_REMW, MDU_REMUW};
   endfunction

   // rs1 is interpreted as signed
   function automatic logic is_signed(input logic [3:0] op);
      return op inside {MDU_MULH, MDU_MULHSU, MDU_DIV, MDU_REM, MDU_DIVW, MDU_REMW};
   endfunction

   // rs2 is interpreted as signed (mulhsu keeps rs2 unsigned)
   function automatic logic src2_signed(input logic [3:0] op);
      return op inside {MDU_MULH, MDU_DIV, MDU_REM, MDU_DIVW, MDU_REMW};
   endfunction

   function automatic logic is_legal(input logic [3:0] op);
      return is_div(op) || (op inside {MDU_MUL, MDU_MULH, MDU_MULHSU, MDU_MULHU, MDU_MULW});
   endfunction

endpackage

// File: rtl/mdu_if.sv
// Decode-side request / writeback-side response bundle of the multiply/divide unit.
interface mdu_if #(parameter int XLEN = 64);
   logic            in_valid;
   logic            in_ready;
   logic [3:0]      mulctr;
   logic [XLEN-1:0] src1;
   logic [XLEN-1:0] src2;
   logic            flush;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] result;
   logic            busy;

   modport master (
      output in_valid, mulctr, src1, src2, flush, out_ready,
      input  in_ready, out_valid, result, busy
   );

   modport slave (
      input  in_valid, mulctr, src1, src2, flush, out_ready,
      output in_ready, out_valid, result, busy
   );
endinterface

// File: rtl/mdu_div_step.sv
// One radix-2 restoring division step: shift in the next dividend bit, then
// subtract the divisor if it fits.
module mdu_div_step #(
   parameter int XLEN = 64
) (
   input  logic [XLEN-1:0] rem_i,
   input  logic [XLEN-1:0] divisor_i,
   input  logic            bit_i,
   output logic [XLEN-1:0] rem_o,
   output logic            q_o
);
   logic [XLEN:0] shifted;
   logic [XLEN:0] diff;

   // rem_i < divisor_i always holds, so the restored value never exceeds XLEN bits
   always_comb begin
      shifted = {rem_i, bit_i};
      diff    = shifted - {1'b0, divisor_i};
      q_o     = ~diff[XLEN];
      rem_o   = q_o ? diff[XLEN-1:0] : shifted[XLEN-1:0];
   end
endmodule

// File: rtl/mdu_iter.sv
// Iterative RV64M multiply/divide unit, one bit per cycle, with divide shortcuts.
//   state | meaning
//   IDLE  | waiting for a legal op; in_ready=1
//   CALC  | iterating, counter counts N down to 1
//   DONE  | result registered, out_valid=1 until out_ready
module mdu_iter
   import mdu_pkg::*;
#(
   parameter int XLEN  = 64,
   parameter int CNT_W = 7
) (
   input  logic clk,
   input  logic rst,
   mdu_if.slave bus
);
   localparam int HALF = XLEN / 2;

   mdu_state_e        state_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [2*XLEN-1:0] acc_q;
   logic [XLEN-1:0]   b_q;
   logic [3:0]        op_q;
   logic              neg_q;
   logic [XLEN-1:0]   result_q;
   logic              out_valid_q;

   function automatic logic [XLEN-1:0] sext_half(input logic [HALF-1:0] v);
      return {{HALF{v[HALF-1]}}, v};
   endfunction

   // operand preparation at acceptance
   logic            w_op, s1, s2, div_zero, div_ovf, accept_short;
   logic [XLEN-1:0] a_ext, b_ext, mag_a, mag_b, min_val, short_res;
   logic [2*XLEN-1:0] acc_load;
   logic [XLEN-1:0]   b_load;

   always_comb begin
      w_op  = is_w(bus.mulctr);
      a_ext = bus.src1;
      b_ext = bus.src2;
      if (w_op) begin
         if (is_div(bus.mulctr) && is_signed(bus.mulctr)) begin
            a_ext = sext_half(bus.src1[HALF-1:0]);
            b_ext = sext_half(bus.src2[HALF-1:0]);
         end else begin
            a_ext = {{HALF{1'b0}}, bus.src1[HALF-1:0]};
            b_ext = {{HALF{1'b0}}, bus.src2[HALF-1:0]};
         end
      end
      s1    = is_signed(bus.mulctr) & a_ext[XLEN-1];
      s2    = src2_signed(bus.mulctr) & b_ext[XLEN-1];
      mag_a = s1 ? -a_ext : a_ext;
      mag_b = s2 ? -b_ext : b_ext;

      min_val  = w_op ? {{(HALF+1){1'b1}}, {(HALF-1){1'b0}}} : {1'b1, {(XLEN-1){1'b0}}};
      div_zero = is_div(bus.mulctr) && (b_ext == '0);
      div_ovf  = is_div(bus.mulctr) && src2_signed(bus.mulctr) &&
                 (a_ext == min_val) && (&b_ext);
      accept_short = div_zero || div_ovf;

      if (is_rem(bus.mulctr))
         short_res = div_zero ? (w_op ? sext_half(bus.src1[HALF-1:0]) : bus.src1) : '0;
      else
         short_res = div_zero ? '1 : a_ext;

      // divide shifts the dividend out MSB-first, so W dividends sit in the top half
      if (is_div(bus.mulctr)) begin
         acc_load = {{XLEN{1'b0}}, (w_op ? (mag_a << HALF) : mag_a)};
         b_load   = mag_b;
      end else begin
         acc_load = {{XLEN{1'b0}}, mag_b};
         b_load   = mag_a;
      end
   end

   // one iteration of either datapath
   logic [XLEN-1:0]   div_rem;
   logic              div_q;
   logic [XLEN-1:0]   mul_addend;
   logic [XLEN:0]     mul_sum;
   logic [2*XLEN-1:0] acc_d;
   logic [2*XLEN-1:0] prod;
   logic [XLEN-1:0]   div_val;
   logic [XLEN-1:0]   result_d;

   mdu_div_step #(.XLEN(XLEN)) u_div_step (
      .rem_i     (acc_q[2*XLEN-1:XLEN]),
      .divisor_i (b_q),
      .bit_i     (acc_q[XLEN-1]),
      .rem_o     (div_rem),
      .q_o       (div_q)
   );

   always_comb begin
      mul_addend = acc_q[0] ? b_q : '0;
      mul_sum    = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, mul_addend};
      if (is_div(op_q))
         acc_d = {div_rem, acc_q[XLEN-2:0], div_q};
      else
         acc_d = {mul_sum, acc_q[XLEN-1:1]};

      div_val = is_rem(op_q) ? acc_d[2*XLEN-1:XLEN] : acc_d[XLEN-1:0];
      if (neg_q)
         div_val = -div_val;
      prod = neg_q ? -acc_d : acc_d;

      // mulw stops after HALF shifts, leaving its product at acc[3*HALF-1:HALF]
      result_d = prod[2*XLEN-1:XLEN];
      if (is_div(op_q))
         result_d = is_w(op_q) ? sext_half(div_val[HALF-1:0]) : div_val;
      else if (op_q == MDU_MUL)
         result_d = prod[XLEN-1:0];
      else if (op_q == MDU_MULW)
         result_d = sext_half(acc_d[XLEN-1:HALF]);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         acc_q       <= '0;
         b_q         <= '0;
         op_q        <= MDU_NONE;
         neg_q       <= 1'b0;
         result_q    <= '0;
         out_valid_q <= 1'b0;
      end else if (bus.flush) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (bus.in_valid && is_legal(bus.mulctr)) begin
                  op_q  <= bus.mulctr;
                  neg_q <= is_rem(bus.mulctr) ? s1 : (s1 ^ s2);
                  acc_q <= acc_load;
                  b_q   <= b_load;
                  if (accept_short) begin
                     result_q    <= short_res;
                     out_valid_q <= 1'b1;
                     state_q     <= DONE;
                  end else begin
                     cnt_q   <= w_op ? CNT_W'(HALF) : CNT_W'(XLEN);
                     state_q <= CALC;
                  end
               end
            end
            CALC: begin
               acc_q <= acc_d;
               cnt_q <= cnt_q - CNT_W'(1);
               if (cnt_q == CNT_W'(1)) begin
                  result_q    <= result_d;
                  out_valid_q <= 1'b1;
                  state_q     <= DONE;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.in_ready  = (state_q == IDLE);
   assign bus.busy      = (state_q != IDLE);
   assign bus.out_valid = out_valid_q;
   assign bus.result    = result_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter: directed cases plus randomized ops checked
// against an arithmetic reference model.
module tb_mdu_iter;
   import mdu_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   mdu_if #(.XLEN(64)) bus();
   mdu_iter #(.XLEN(64), .CNT_W(7)) dut (.clk(clk), .rst(rst), .bus(bus));

   int compared   = 0;
   int mismatched = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] sx32(input logic [31:0] v);
      return {{32{v[31]}}, v};
   endfunction

   function automatic logic [63:0] ref_res(input logic [3:0] op, input logic [63:0] a,
                                           input logic [63:0] b);
      logic [127:0]       p;
      logic signed [63:0] sa, sb;
      logic signed [31:0] wa, wb;
      logic [31:0]        ua, ub, t;
      logic [63:0]        r;
      logic               ovf64, ovf32;
      sa = a; sb = b; wa = a[31:0]; wb = b[31:0]; ua = a[31:0]; ub = b[31:0];
      ovf64 = (a == 64'h8000_0000_0000_0000) && (b == '1);
      ovf32 = (ua == 32'h8000_0000) && (ub == 32'hFFFF_FFFF);
      r = '0;
      case (op)
         MDU_MUL:    r = a * b;
         MDU_MULH:   begin p = {{64{a[63]}}, a} * {{64{b[63]}}, b}; r = p[127:64]; end
         MDU_MULHSU: begin p = {{64{a[63]}}, a} * {64'd0, b};       r = p[127:64]; end
         MDU_MULHU:  begin p = {64'd0, a} * {64'd0, b};             r = p[127:64]; end
         MDU_MULW:   begin t = ua * ub; r = sx32(t); end
         MDU_DIV:    r = (b == 0) ? '1 : ovf64 ? a : 64'(sa / sb);
         MDU_DIVU:   r = (b == 0) ? '1 : a / b;
         MDU_REM:    r = (b == 0) ? a : ovf64 ? 64'd0 : 64'(sa % sb);
         MDU_REMU:   r = (b == 0) ? a : a % b;
         MDU_DIVW:   r = (ub == 0) ? '1 : ovf32 ? sx32(ua) : sx32(32'(wa / wb));
         MDU_DIVUW:  r = (ub == 0) ? '1 : sx32(ua / ub);
         MDU_REMW:   r = (ub == 0) ? sx32(ua) : ovf32 ? 64'd0 : sx32(32'(wa % wb));
         MDU_REMUW:  r = (ub == 0) ? sx32(ua) : sx32(ua % ub);
         default:    r = '0;
      endcase
      return r;
   endfunction

   // edges from the acceptance edge (inclusive) until out_valid is seen
   function automatic int ref_lat(input logic [3:0] op, input logic [63:0] a,
                                  input logic [63:0] b);
      bit w, d, zero, ovf;
      w    = op inside {MDU_MULW, MDU_DIVW, MDU_DIVUW, MDU_REMW, MDU_REMUW};
      d    = op inside {MDU_DIV, MDU_DIVU, MDU_REM, MDU_REMU,
                        MDU_DIVW, MDU_DIVUW, MDU_REMW, MDU_REMUW};
      zero = w ? (b[31:0] == 0) : (b == 0);
      ovf  = ((op inside {MDU_DIV, MDU_REM}) && a == 64'h8000_0000_0000_0000 && b == '1) ||
             ((op inside {MDU_DIVW, MDU_REMW}) && a[31:0] == 32'h8000_0000 &&
              b[31:0] == 32'hFFFF_FFFF);
      if (d && (zero || ovf)) return 1;
      return w ? 33 : 65;
   endfunction

   function automatic logic [63:0] rnd_opnd();
      logic [63:0] v;
      case ($urandom_range(0, 6))
         0: v = 64'd0;
         1: v = '1;
         2: v = 64'h8000_0000_0000_0000;
         3: v = 64'hFFFF_FFFF_8000_0000;
         4: v = 64'($urandom_range(0, 40));
         5: v = -64'($urandom_range(1, 40));
         default: v = {$urandom, $urandom};
      endcase
      return v;
   endfunction

   task automatic run_op(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                         input int hold, input string tag);
      logic [63:0] exp_r;
      int          exp_l, edges;
      exp_r = ref_res(op, a, b);
      exp_l = ref_lat(op, a, b);
      chk({tag, "/in_ready"}, 64'(bus.in_ready), 64'd1);
      bus.in_valid = 1'b1;
      bus.mulctr   = op;
      bus.src1     = a;
      bus.src2     = b;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      bus.mulctr   = MDU_NONE;
      edges = 1;
      while (!bus.out_valid && edges < 200) begin
         @(posedge clk); #1;
         edges++;
      end
      chk({tag, "/latency"}, 64'(edges), 64'(exp_l));
      chk({tag, "/result"}, bus.result, exp_r);
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         chk({tag, "/hold_valid"}, {62'd0, bus.out_valid, bus.in_ready}, 64'd2);
         chk({tag, "/hold_result"}, bus.result, exp_r);
      end
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      chk({tag, "/to_idle"}, {61'd0, bus.in_ready, bus.out_valid, bus.busy}, 64'd4);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   logic [3:0]  rops [13];
   logic [3:0]  op;
   logic        seen;

   initial begin
      rops = '{MDU_MUL, MDU_MULH, MDU_MULHSU, MDU_MULHU, MDU_MULW,
               MDU_DIV, MDU_DIVU, MDU_REM, MDU_REMU,
               MDU_DIVW, MDU_DIVUW, MDU_REMW, MDU_REMUW};
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.mulctr    = MDU_NONE;
      bus.src1      = '0;
      bus.src2      = '0;
      bus.flush     = 1'b0;
      bus.out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset/flags", {61'd0, bus.in_ready, bus.out_valid, bus.busy}, 64'd4);
      chk("reset/result", bus.result, 64'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      run_op(MDU_MUL,   64'd7, -64'd3, 0, "mul_7x-3");
      run_op(MDU_MULHU, '1, '1, 0, "mulhu_ones");
      run_op(MDU_MULH,  '1, '1, 0, "mulh_ones");
      run_op(MDU_DIVW,  64'h8000_0000, 64'hFFFF_FFFF, 0, "divw_ovf");
      run_op(MDU_REMW,  64'h8000_0000, 64'hFFFF_FFFF, 0, "remw_ovf");
      run_op(MDU_DIV,   64'd100, 64'd0, 0, "div_by0");
      run_op(MDU_REM,   64'd100, 64'd0, 0, "rem_by0");
      run_op(MDU_REM,   -64'd7, 64'd2, 0, "rem_-7_2");
      run_op(MDU_DIVU,  64'd1000, 64'd7, 10, "divu_hold");

      // illegal codes are never accepted
      bus.in_valid = 1'b1;
      bus.mulctr   = 4'b0000;
      @(posedge clk); #1;
      chk("illegal_0000", {62'd0, bus.in_ready, bus.busy}, 64'd2);
      bus.mulctr = 4'b1010;
      @(posedge clk); #1;
      chk("illegal_1010", {62'd0, bus.in_ready, bus.busy}, 64'd2);
      bus.in_valid = 1'b0;
      bus.mulctr   = MDU_NONE;

      // flush in the middle of a divide
      bus.in_valid = 1'b1;
      bus.mulctr   = MDU_DIV;
      bus.src1     = 64'd12345;
      bus.src2     = 64'd67;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      chk("flush_calc/busy", 64'(bus.busy), 64'd1);
      repeat (19) @(posedge clk);
      #1;
      bus.flush = 1'b1;
      @(posedge clk); #1;
      bus.flush = 1'b0;
      chk("flush_calc/idle", {61'd0, bus.in_ready, bus.out_valid, bus.busy}, 64'd4);
      seen = 1'b0;
      repeat (70) begin
         @(posedge clk); #1;
         if (bus.out_valid) seen = 1'b1;
      end
      chk("flush_calc/no_valid", 64'(seen), 64'd0);
      run_op(MDU_REMUW, 64'd10, 64'd3, 0, "remuw_10_3");

      // flush coinciding with in_valid blocks acceptance
      bus.in_valid = 1'b1;
      bus.flush    = 1'b1;
      bus.mulctr   = MDU_MUL;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      bus.flush    = 1'b0;
      chk("flush_accept/busy", 64'(bus.busy), 64'd0);

      // flush in DONE discards the result
      bus.in_valid = 1'b1;
      bus.mulctr   = MDU_DIV;
      bus.src1     = 64'd5;
      bus.src2     = 64'd0;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      chk("flush_done/valid_before", 64'(bus.out_valid), 64'd1);
      bus.flush = 1'b1;
      @(posedge clk); #1;
      bus.flush = 1'b0;
      chk("flush_done/after", {61'd0, bus.in_ready, bus.out_valid, bus.busy}, 64'd4);

      for (int i = 0; i < 30; i++) begin
         op = rops[$urandom_range(0, 12)];
         run_op(op, rnd_opnd(), rnd_opnd(), int'($urandom_range(0, 2)), $sformatf("rand%0d_op%b", i, op));
      end

      // asynchronous reset in the middle of a computation
      run_op(MDU_DIVU, 64'd1000, 64'd7, 0, "divu_pre_reset");
      bus.in_valid = 1'b1;
      bus.mulctr   = MDU_MULHU;
      bus.src1     = '1;
      bus.src2     = 64'd3;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      repeat (10) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("async_rst/flags", {61'd0, bus.in_ready, bus.out_valid, bus.busy}, 64'd4);
      chk("async_rst/result", bus.result, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      run_op(MDU_MUL, 64'd7, -64'd3, 0, "mul_after_reset");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/mdu_iter.md
Name: mdu_iter

Overview:
- Iterative multiply/divide unit for RV64M, directly downstream of the decode stage.
- Consumes the decoder's 4-bit MULctr code plus two 64-bit operands and computes one result per operation at one bit per cycle.
- Returns a 64-bit result to the EX/writeback path over a valid/ready handshake.
- Stalls the pipeline while busy; can be aborted by a flush.

Parameters:
- XLEN, 64, datapath width; only 64 is supported.
- CNT_W, 7, iteration counter width; must hold XLEN.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  operation offered.
- in_ready  out  1  unit can accept; equals (state==IDLE).
- mulctr  in  4  decoder MULctr code; 0000 = none.
- src1  in  XLEN  rs1 operand (dividend / multiplicand).
- src2  in  XLEN  rs2 operand (divisor / multiplier).
- flush  in  1  synchronous abort.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes the result.
- result  out  XLEN  final value, already sign-extended for W ops.
- busy  out  1  state!=IDLE; used as a stall request.

Behaviour:
- Reset (async): state=IDLE, counter=0, out_valid=0, result=0, busy=0, in_ready=1.
- MULctr encoding:
  - 1001 mul, 0001 mulh, 0010 mulhsu, 0011 mulhu
  - 0100 div, 0101 divu, 0110 rem, 0111 remu
  - 1000 mulw, 1100 divw, 1101 divuw, 1110 remw, 1111 remuw
  - Any other code, including 0000, is never accepted; in_ready stays 1.
- Acceptance: on an edge where in_valid && in_ready && legal mulctr && !flush. Operands and op are latched at that edge.
- States: IDLE -> CALC -> DONE -> IDLE.
  - IDLE->CALC on acceptance; counter loads N, where N=64, or 32 for W ops.
  - CALC: one iteration per cycle, counter decrements; at counter==1 the next edge moves to DONE.
  - DONE: out_valid=1 and result is stable. Leaves to IDLE on the edge where out_ready=1. Holds indefinitely otherwise.
- Latency: out_valid asserts N+1 edges after the acceptance edge (65 for 64-bit ops, 33 for W ops).
- Shortcut, IDLE->DONE in 1 edge, for these cases (RISC-V spec results):
  - Divide by zero: quotient = all ones (W: 0xFFFFFFFF sign-extended); remainder = dividend (W: low 32 bits sign-extended).
  - Signed overflow (dividend = most-negative, divisor = -1): quotient = dividend; remainder = 0. For W ops the test uses the 32-bit values.
- Signed handling:
  - Magnitudes are taken before iterating; the result is negated at DONE entry.
  - Product sign = s1^s2; mulhsu treats src2 as unsigned.
  - Quotient sign = s1^s2; remainder sign = s1.
- Multiply: shift-add into a 128-bit accumulator.
  - mul returns the low 64 bits.
  - mulh, mulhsu, mulhu return the high 64 bits.
  - mulw uses the low 32 bits of each operand and returns product[31:0] sign-extended.
- Divide: radix-2 restoring.
  - W ops use 32-bit operands, sign-extended for divw/remw and zero-extended for divuw/remuw.
  - The 32-bit result is sign-extended to 64 bits in all W cases.
- Flush: sampled every edge and has priority over everything.
  - From any state, the next state is IDLE and out_valid drops.
  - A flush in the same cycle as in_valid blocks acceptance.
  - A flush in DONE discards the pending result.
- Back-to-back: leaving DONE returns to IDLE. A new op can be accepted one cycle later, never in the same cycle as the out_ready handshake.
- result holds its last value in IDLE; only out_valid qualifies it.

Decomposition:
- Shared package mdu_pkg holds:
  - MULctr code localparams (MDU_MUL … MDU_REMUW) plus is_w/is_div/is_signed decode helpers.
  - State encoding IDLE/CALC/DONE.
- The decoder and this unit both import the MULctr codes from mdu_pkg.
- One sub-module, mdu_div_step: combinational restoring-divide step taking partial remainder, divisor, and next dividend bit, and producing the new remainder and quotient bit.
- The multiply step stays inline.

Test Plan:
- mul src1=7, src2=-3 -> out_valid exactly 65 edges after acceptance; result=0xFFFFFFFFFFFFFFEB.
- mulhu src1=src2=0xFFFFFFFFFFFFFFFF -> result=0xFFFFFFFFFFFFFFFE. Then mulh with the same operands -> result=0.
- divw src1=0x80000000 (low 32), src2=0xFFFFFFFF -> shortcut, out_valid after 1 edge, result=0xFFFFFFFF80000000. Then remw with the same operands -> result=0.
- div src1=100, src2=0 -> result=0xFFFFFFFFFFFFFFFF after 1 edge. Then rem src1=100, src2=0 -> result=100. Then rem src1=-7, src2=2 -> result=-1 after 65 edges.
- divu src1=1000, src2=7 with out_ready held 0 for 10 cycles -> out_valid and result=142 stable throughout; in_ready=0; goes IDLE on the edge out_ready rises.
- Flush mid-CALC (cycle 20 of a div) -> IDLE next edge, out_valid never rises. Then a new remuw 10 % 3 -> result=1 after 33 edges.
- Async reset mid-CALC -> outputs immediately go to reset values.
